// File: rtl/test_sequencer.sv
// test_sequencer: runs NUM_TESTS test elements one at a time with a per-test
// watchdog, a dead cycle between tests and a latched pass/fail summary.
module test_sequencer #(
  parameter int unsigned NUM_TESTS      = 7,
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter int unsigned CNT_W          = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 done,
  input  logic [NUM_TESTS-1:0] fail_in,
  output logic [NUM_TESTS-1:0] en,
  output logic                 busy,
  output logic                 finished,
  output logic                 pass,
  output logic [NUM_TESTS-1:0] fails,
  output logic [NUM_TESTS-1:0] timeouts,
  output logic [4:0]           cur_test
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_GAP,
    S_FINISH
  } state_t;

  state_t               r_state, w_state_nxt;
  logic [CNT_W-1:0]     r_cnt, w_cnt_nxt;
  logic [NUM_TESTS-1:0] r_en, w_en_nxt;
  logic [NUM_TESTS-1:0] r_fails, w_fails_nxt;
  logic [NUM_TESTS-1:0] r_touts, w_touts_nxt;
  logic [4:0]           r_cur, w_cur_nxt;
  logic                 r_busy, r_fin, r_pass;
  logic                 w_busy_nxt, w_fin_nxt, w_pass_nxt;
  logic                 w_expire;

  // Watchdog expiry on the last allowed cycle of the active test
  assign w_expire = (TIMEOUT_CYCLES != 0) && (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  // Next-state and next-output logic; r_en doubles as the active-test mask
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_en_nxt    = r_en;
    w_fails_nxt = r_fails;
    w_touts_nxt = r_touts;
    w_cur_nxt   = r_cur;
    case (r_state)
      S_IDLE, S_FINISH: begin
        if (start) begin
          w_state_nxt = S_RUN;
          w_en_nxt    = NUM_TESTS'(1);
          w_cur_nxt   = 5'd0;
          w_cnt_nxt   = '0;
          w_fails_nxt = '0;
          w_touts_nxt = '0;
        end
      end
      S_RUN: begin
        w_cnt_nxt = r_cnt + CNT_W'(1);
        if (done) begin
          w_fails_nxt = (r_fails & ~r_en) | (fail_in & r_en);
          w_en_nxt    = '0;
          w_state_nxt = S_GAP;
        end else if (w_expire) begin
          w_fails_nxt = r_fails | r_en;
          w_touts_nxt = r_touts | r_en;
          w_en_nxt    = '0;
          w_state_nxt = S_GAP;
        end
      end
      S_GAP: begin
        w_en_nxt = '0;
        if (!done) begin
          if (r_cur == 5'(NUM_TESTS - 1)) begin
            w_state_nxt = S_FINISH;
          end else begin
            w_state_nxt = S_RUN;
            w_cur_nxt   = r_cur + 5'd1;
            w_en_nxt    = NUM_TESTS'(1) << w_cur_nxt;
            w_cnt_nxt   = '0;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
    w_busy_nxt = (w_state_nxt == S_RUN) || (w_state_nxt == S_GAP);
    w_fin_nxt  = (w_state_nxt == S_FINISH);
    w_pass_nxt = w_fin_nxt && (w_fails_nxt == '0);
  end

  // State and registered outputs with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_en    <= '0;
      r_fails <= '0;
      r_touts <= '0;
      r_cur   <= 5'd0;
      r_busy  <= 1'b0;
      r_fin   <= 1'b0;
      r_pass  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_en    <= w_en_nxt;
      r_fails <= w_fails_nxt;
      r_touts <= w_touts_nxt;
      r_cur   <= w_cur_nxt;
      r_busy  <= w_busy_nxt;
      r_fin   <= w_fin_nxt;
      r_pass  <= w_pass_nxt;
    end
  end

  assign en       = r_en;
  assign busy     = r_busy;
  assign finished = r_fin;
  assign pass     = r_pass;
  assign fails    = r_fails;
  assign timeouts = r_touts;
  assign cur_test = r_cur;

endmodule
